// File: rtl/ti_simon_arbiter.sv
// Two-requester round-robin front end for a threshold-implementation Simon core.
// It grants one job at a time, watches the core for completion or timeout, and returns the unmasked result.
module ti_simon_arbiter #(
    parameter int TIMEOUT = 16384
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         req0,
    input  logic         req1,
    input  logic [767:0] din0,
    input  logic [767:0] din1,
    output logic         ack0,
    output logic         ack1,
    output logic [127:0] dout0,
    output logic [127:0] dout1,
    output logic         err,
    output logic [767:0] core_din,
    output logic         core_drdy,
    output logic         core_en,
    input  logic         core_dvld,
    input  logic [127:0] core_dout,
    input  logic         core_bsy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam logic [14:0] CNT_LAST = 15'(TIMEOUT - 1);

    state_t      state;
    logic        last;
    logic        gnt;
    logic [14:0] cnt;
    logic        pick;

    // A lone requester always wins; under contention the one not served last goes first.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            last      <= 1'b1;
            gnt       <= 1'b0;
            cnt       <= '0;
            core_din  <= '0;
            core_drdy <= 1'b0;
            core_en   <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err       <= 1'b0;
            dout0     <= '0;
            dout1     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if ((req0 || req1) && !core_bsy) begin
                        gnt       <= pick;
                        core_din  <= pick ? din1 : din0;
                        core_drdy <= 1'b1;
                        core_en   <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    core_drdy <= 1'b0;
                    cnt       <= '0;
                    state     <= RUN;
                end
                RUN: begin
                    if (core_dvld) begin
                        state <= WAIT;
                    end else if (cnt == CNT_LAST) begin
                        // Abort: the requester still gets its ack, flagged by err, with a cleared result.
                        core_en <= 1'b0;
                        err     <= 1'b1;
                        state   <= RESP;
                        if (gnt) begin
                            ack1  <= 1'b1;
                            dout1 <= '0;
                        end else begin
                            ack0  <= 1'b1;
                            dout0 <= '0;
                        end
                    end else begin
                        cnt <= cnt + 15'd1;
                    end
                end
                WAIT: begin
                    // The core presents its result one cycle after flagging it valid.
                    core_en <= 1'b0;
                    state   <= RESP;
                    if (gnt) begin
                        ack1  <= 1'b1;
                        dout1 <= core_dout;
                    end else begin
                        ack0  <= 1'b1;
                        dout0 <= core_dout;
                    end
                end
                RESP: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    err   <= 1'b0;
                    last  <= gnt;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ti_simon_arbiter.sv
// Directed bench for ti_simon_arbiter: a behavioural core model drives the main instance,
// and a second instance with a short timeout is driven by hand for abort behaviour.
module tb_ti_simon_arbiter;

    localparam logic [767:0] P0 = {24{32'h0123_4567}};
    localparam logic [767:0] P1 = {24{32'h89AB_CDEF}};
    localparam logic [767:0] PQ = {24{32'hFFFF_0000}};

    logic         CLK = 1'b0;
    logic         RST;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [767:0] din0 = '0, din1 = '0;
    logic         ack0, ack1, err;
    logic [127:0] dout0, dout1;
    logic [767:0] core_din;
    logic         core_drdy, core_en;
    logic         core_dvld = 1'b0;
    logic [127:0] core_dout = '0;
    logic         core_bsy = 1'b0;

    logic         req0_t = 1'b0, req1_t = 1'b0;
    logic         ack0_t, ack1_t, err_t;
    logic [127:0] dout0_t, dout1_t;
    logic [767:0] core_din_t;
    logic         core_drdy_t, core_en_t;
    logic         core_dvld_t = 1'b0;
    logic [127:0] core_dout_t = '0;
    logic         core_bsy_t = 1'b0;

    int           checks = 0;
    int           errors = 0;
    int           dvld_at = 1000;
    logic [127:0] core_val = '0;
    int           run_cyc = -1;
    int           run_nxt;

    ti_simon_arbiter dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .req1(req1), .din0(din0), .din1(din1),
        .ack0(ack0), .ack1(ack1), .dout0(dout0), .dout1(dout1), .err(err),
        .core_din(core_din), .core_drdy(core_drdy), .core_en(core_en),
        .core_dvld(core_dvld), .core_dout(core_dout), .core_bsy(core_bsy)
    );

    ti_simon_arbiter #(.TIMEOUT(64)) dut_to (
        .CLK(CLK), .RST(RST),
        .req0(req0_t), .req1(req1_t), .din0(din0), .din1(din1),
        .ack0(ack0_t), .ack1(ack1_t), .dout0(dout0_t), .dout1(dout1_t), .err(err_t),
        .core_din(core_din_t), .core_drdy(core_drdy_t), .core_en(core_en_t),
        .core_dvld(core_dvld_t), .core_dout(core_dout_t), .core_bsy(core_bsy_t)
    );

    always #5 CLK = ~CLK;

    // Core model: RUN cycle 0 starts at the edge that samples core_drdy; core_dvld is raised
    // in RUN cycle dvld_at and the result appears on core_dout the following cycle.
    always_comb run_nxt = core_drdy ? 0 : ((run_cyc >= 0) ? run_cyc + 1 : -1);

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            run_cyc   <= -1;
            core_dvld <= 1'b0;
        end else begin
            core_dvld <= (run_nxt >= 0) && (run_nxt == dvld_at);
            run_cyc   <= ((run_nxt >= 0) && (run_nxt == dvld_at)) ? -1 : run_nxt;
            if (core_drdy) core_dout <= {4{32'hDEAD_BEEF}};
            else if (core_dvld) core_dout <= core_val;
        end
    end

    function automatic logic sel(input int which);
        case (which)
            0: return core_drdy;
            1: return ack0 | ack1;
            2: return core_drdy_t;
            3: return ack0_t | ack1_t;
            default: return 1'b0;
        endcase
    endfunction

    // Counts falling edges until the selected signal is seen high; n = -1 if the bound expires.
    task automatic wait_sig(input int which, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge CLK);
            if (sel(which) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        #1 RST = 1'b1;
        repeat (3) @(negedge CLK);
        checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL reset_core_en: got %b expected 0", core_en); end
        checks++; if (core_drdy !== 1'b0) begin errors++; $display("FAIL reset_core_drdy: got %b expected 0", core_drdy); end
        checks++; if ({ack0, ack1, err} !== 3'b000) begin errors++; $display("FAIL reset_ack_err: got %b expected 000", {ack0, ack1, err}); end
        checks++; if (core_din !== 768'h0) begin errors++; $display("FAIL reset_core_din: got %h expected 0", core_din); end
        checks++; if (dout0 !== 128'h0) begin errors++; $display("FAIL reset_dout0: got %h expected 0", dout0); end
        checks++; if (dout1 !== 128'h0) begin errors++; $display("FAIL reset_dout1: got %h expected 0", dout1); end
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        checks++; if ({core_en, core_drdy} !== 2'b00) begin errors++; $display("FAIL idle_no_req: got en,drdy=%b expected 00", {core_en, core_drdy}); end
    endtask

    task automatic test_single();
        int n;
        logic [127:0] exp_v;
        exp_v = {16{8'hA5}};
        din0 = P0; dvld_at = 300; core_val = exp_v; req0 = 1'b1;
        wait_sig(0, 5, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL single_grant_latency: got %0d expected 1", n); end
        checks++; if (core_din !== P0) begin errors++; $display("FAIL single_core_din: got %h expected %h", core_din, P0); end
        checks++; if (core_en !== 1'b1) begin errors++; $display("FAIL single_load_en: got %b expected 1", core_en); end
        @(negedge CLK);
        checks++; if ({core_drdy, core_en} !== 2'b01) begin errors++; $display("FAIL single_run_drdy_en: got %b expected 01", {core_drdy, core_en}); end
        wait_sig(1, 400, n);
        checks++; if (n !== dvld_at + 2) begin errors++; $display("FAIL single_ack_latency: got %0d expected %0d", n, dvld_at + 2); end
        checks++; if ({ack1, ack0} !== 2'b01) begin errors++; $display("FAIL single_ack_sel: got %b expected 01", {ack1, ack0}); end
        checks++; if (dout0 !== exp_v) begin errors++; $display("FAIL single_dout0: got %h expected %h", dout0, exp_v); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", err); end
        req0 = 1'b0;
        @(negedge CLK);
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL single_ack_pulse: got %b expected 0", ack0); end
    endtask

    task automatic test_round_robin();
        int n;
        logic [127:0] v1, v2, v3;
        v1 = {8{16'h1234}}; v2 = {8{16'h5678}}; v3 = {8{16'h9ABC}};
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        din0 = P0; din1 = P1; dvld_at = 4; core_val = v1;
        req0 = 1'b1; req1 = 1'b1;
        wait_sig(0, 5, n);
        checks++; if (n !== 1 || core_din !== P0) begin errors++; $display("FAIL rr_first_grant: got n=%0d din=%h expected n=1 din=%h", n, core_din, P0); end
        wait_sig(1, 20, n);
        checks++; if (n !== dvld_at + 3) begin errors++; $display("FAIL rr_first_latency: got %0d expected %0d", n, dvld_at + 3); end
        checks++; if ({ack1, ack0} !== 2'b01) begin errors++; $display("FAIL rr_first_ack: got %b expected 01", {ack1, ack0}); end
        checks++; if (dout0 !== v1) begin errors++; $display("FAIL rr_first_dout0: got %h expected %h", dout0, v1); end
        req0 = 1'b0; core_val = v2;
        wait_sig(0, 5, n);
        checks++; if (n !== 2) begin errors++; $display("FAIL rr_gap: got %0d expected 2", n); end
        checks++; if (core_din !== P1) begin errors++; $display("FAIL rr_second_din: got %h expected %h", core_din, P1); end
        wait_sig(1, 20, n);
        checks++; if ({ack1, ack0} !== 2'b10) begin errors++; $display("FAIL rr_second_ack: got %b expected 10", {ack1, ack0}); end
        checks++; if (dout1 !== v2) begin errors++; $display("FAIL rr_second_dout1: got %h expected %h", dout1, v2); end
        req1 = 1'b0; core_val = v3;
        @(negedge CLK);
        req0 = 1'b1; req1 = 1'b1;
        wait_sig(0, 5, n);
        checks++; if (n !== 1 || core_din !== P0) begin errors++; $display("FAIL rr_third_grant: got n=%0d din=%h expected n=1 din=%h", n, core_din, P0); end
        wait_sig(1, 20, n);
        checks++; if ({ack1, ack0} !== 2'b01) begin errors++; $display("FAIL rr_third_ack: got %b expected 01", {ack1, ack0}); end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_timeout();
        int n;
        logic [127:0] val;
        for (int j = 0; j < 3; j++) begin
            val = (j == 0) ? {16{8'h3C}} : {16{8'hC3}};
            din0 = (j == 2) ? P1 : P0;
            req0_t = 1'b1;
            wait_sig(2, 5, n);
            checks++; if (n !== 1 || core_din_t !== din0) begin errors++; $display("FAIL to_grant_%0d: got n=%0d din=%h expected n=1 din=%h", j, n, core_din_t, din0); end
            core_dout_t = '1;
            if (j == 1) begin
                for (int k = 1; k <= 64; k++) @(negedge CLK);
                checks++; if ({core_en_t, ack0_t, err_t} !== 3'b100) begin errors++; $display("FAIL to_last_run: got en,ack,err=%b expected 100", {core_en_t, ack0_t, err_t}); end
                @(negedge CLK);
                checks++; if ({ack0_t, err_t} !== 2'b11) begin errors++; $display("FAIL to_abort_ack_err: got %b expected 11", {ack0_t, err_t}); end
                checks++; if (dout0_t !== 128'h0) begin errors++; $display("FAIL to_abort_dout: got %h expected 0", dout0_t); end
            end else begin
                @(negedge CLK);
                core_dvld_t = 1'b1;
                @(negedge CLK);
                core_dvld_t = 1'b0; core_dout_t = val;
                @(negedge CLK);
                checks++; if ({ack0_t, err_t} !== 2'b10) begin errors++; $display("FAIL to_normal_%0d_ack_err: got %b expected 10", j, {ack0_t, err_t}); end
                checks++; if (dout0_t !== val) begin errors++; $display("FAIL to_normal_%0d_dout: got %h expected %h", j, dout0_t, val); end
            end
            req0_t = 1'b0;
            @(negedge CLK);
            checks++; if ({ack0_t, err_t} !== 2'b00) begin errors++; $display("FAIL to_resp_end_%0d: got %b expected 00", j, {ack0_t, err_t}); end
        end
        checks++; if (dout1_t !== 128'h0) begin errors++; $display("FAIL to_dout1_untouched: got %h expected 0", dout1_t); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        int acks;
        logic [127:0] v4;
        v4 = {4{32'h0BAD_F00D}};
        din1 = P1; dvld_at = 50; core_val = v4; req1 = 1'b1;
        wait_sig(0, 5, n);
        checks++; if (n !== 1 || core_din !== P1) begin errors++; $display("FAIL rst_pre_grant: got n=%0d din=%h expected n=1 din=%h", n, core_din, P1); end
        repeat (10) @(negedge CLK);
        checks++; if (core_en !== 1'b1) begin errors++; $display("FAIL rst_pre_running: got %b expected 1", core_en); end
        #2 RST = 1'b1;
        #1;
        checks++; if ({core_en, core_drdy, ack0, ack1, err} !== 5'b0) begin errors++; $display("FAIL rst_async_ctrl: got %b expected 00000", {core_en, core_drdy, ack0, ack1, err}); end
        checks++; if (core_din !== 768'h0) begin errors++; $display("FAIL rst_async_din: got %h expected 0", core_din); end
        checks++; if (dout0 !== 128'h0 || dout1 !== 128'h0) begin errors++; $display("FAIL rst_async_dout: got %h %h expected 0 0", dout0, dout1); end
        acks = 0;
        repeat (3) begin
            @(negedge CLK);
            if (ack0 || ack1) acks++;
        end
        RST = 1'b0;
        wait_sig(0, 5, n);
        checks++; if (n !== 1 || core_din !== P1) begin errors++; $display("FAIL rst_regrant: got n=%0d din=%h expected n=1 din=%h", n, core_din, P1); end
        checks++; if (acks !== 0) begin errors++; $display("FAIL rst_no_ack: got %0d expected 0", acks); end
        wait_sig(1, 80, n);
        checks++; if (n !== dvld_at + 3 || {ack1, ack0} !== 2'b10) begin errors++; $display("FAIL rst_after_ack: got n=%0d ack=%b expected n=%0d ack=10", n, {ack1, ack0}, dvld_at + 3); end
        checks++; if (dout1 !== v4) begin errors++; $display("FAIL rst_after_dout1: got %h expected %h", dout1, v4); end
        req1 = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_din_change_and_drop();
        int n;
        int acks;
        logic [127:0] v5, v4;
        v5 = {2{64'h0F1E_2D3C_4B5A_6978}}; v4 = {4{32'h0BAD_F00D}};
        din0 = P0; dvld_at = 20; core_val = v5; req0 = 1'b1;
        wait_sig(0, 5, n);
        checks++; if (n !== 1 || core_din !== P0) begin errors++; $display("FAIL drop_grant: got n=%0d din=%h expected n=1 din=%h", n, core_din, P0); end
        @(negedge CLK);
        din0 = PQ; req0 = 1'b0;
        @(negedge CLK);
        checks++; if (core_din !== P0) begin errors++; $display("FAIL drop_din_held: got %h expected %h", core_din, P0); end
        wait_sig(1, 40, n);
        checks++; if (n !== dvld_at + 1 || {ack1, ack0} !== 2'b01) begin errors++; $display("FAIL drop_ack: got n=%0d ack=%b expected n=%0d ack=01", n, {ack1, ack0}, dvld_at + 1); end
        checks++; if (dout0 !== v5) begin errors++; $display("FAIL drop_dout0: got %h expected %h", dout0, v5); end
        checks++; if (dout1 !== v4) begin errors++; $display("FAIL drop_dout1_hold: got %h expected %h", dout1, v4); end
        acks = 0;
        repeat (6) begin
            @(negedge CLK);
            if (ack0 || ack1 || core_drdy) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL drop_single_ack: got %0d extra events expected 0", acks); end
    endtask

    task automatic test_bsy();
        int n;
        int busy_evt;
        logic [127:0] v6;
        v6 = {4{32'h7777_1111}};
        core_bsy = 1'b1; din1 = P1; dvld_at = 3; core_val = v6; req1 = 1'b1;
        busy_evt = 0;
        repeat (8) begin
            @(negedge CLK);
            if (core_drdy || core_en) busy_evt++;
        end
        checks++; if (busy_evt !== 0) begin errors++; $display("FAIL bsy_blocked: got %0d events expected 0", busy_evt); end
        core_bsy = 1'b0;
        wait_sig(0, 3, n);
        checks++; if (n !== 1 || core_din !== P1) begin errors++; $display("FAIL bsy_release_grant: got n=%0d din=%h expected n=1 din=%h", n, core_din, P1); end
        wait_sig(1, 20, n);
        checks++; if ({ack1, ack0} !== 2'b10 || dout1 !== v6) begin errors++; $display("FAIL bsy_ack: got ack=%b dout1=%h expected 10 %h", {ack1, ack0}, dout1, v6); end
        req1 = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_reset_mid_run();
        test_din_change_and_drop();
        test_bsy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
